// File: rtl/serial_alu_engine.sv
// Bit-serial ALU tile: two operands shifted in serially, eight operations
// computed LSB first, result/flags/operands muxed onto a parallel output.
module serial_alu_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             load_en,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_PA   = 3'b101,
        OP_PB   = 3'b110,
        OP_ADC  = 3'b111
    } op_t;

    state_t             state;
    op_t                op_q;
    op_t                op_in;
    logic [2*WIDTH-1:0] sreg;
    logic [WIDTH-1:0]   a_w;
    logic [WIDTH-1:0]   b_w;
    logic [WIDTH-1:0]   res;
    logic [WIDTH-1:0]   res_next;
    logic [CW-1:0]      cnt;
    logic               c_run;

    logic a_bit, b_bit, b_eff;
    logic sum_bit, c_out, res_bit, arith;

    assign op_in = op_t'(op);

    // One-bit slice; SUB inverts B and relies on the carry-in of 1.
    always_comb begin
        a_bit   = a_w[0];
        b_bit   = b_w[0];
        b_eff   = (op_q == OP_SUB) ? ~b_bit : b_bit;
        sum_bit = a_bit ^ b_eff ^ c_run;
        c_out   = (a_bit & b_eff) | (c_run & (a_bit ^ b_eff));
        arith   = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_ADC);
        res_bit = sum_bit;
        case (op_q)
            OP_AND:  res_bit = a_bit & b_bit;
            OP_OR:   res_bit = a_bit | b_bit;
            OP_XOR:  res_bit = a_bit ^ b_bit;
            OP_PA:   res_bit = a_bit;
            OP_PB:   res_bit = b_bit;
            default: res_bit = sum_bit;
        endcase
        res_next = {res_bit, res[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= OP_ADD;
            sreg  <= '0;
            a_w   <= '0;
            b_w   <= '0;
            res   <= '0;
            cnt   <= '0;
            c_run <= 1'b0;
            carry <= 1'b0;
            zero  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                EXEC: begin
                    res   <= res_next;
                    a_w   <= a_w >> 1;
                    b_w   <= b_w >> 1;
                    c_run <= c_out;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        carry <= arith & c_out;
                        zero  <= (res_next == '0);
                    end
                end
                default: begin
                    if (start) begin
                        op_q  <= op_in;
                        a_w   <= sreg[2*WIDTH-1:WIDTH];
                        b_w   <= sreg[WIDTH-1:0];
                        c_run <= (op_in == OP_SUB) |
                                 ((op_in == OP_ADC) & carry);
                        cnt   <= '0;
                        state <= EXEC;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        if (load_en)
                            sreg <= {sreg[2*WIDTH-2:0], din};
                    end
                end
            endcase
        end
    end

    always_comb begin
        data_out = '0;
        case (sel)
            2'b00:   data_out = sreg[WIDTH-1:0];
            2'b01:   data_out = sreg[2*WIDTH-1:WIDTH];
            2'b10:   data_out = res;
            default: data_out[1:0] = {zero, carry};
        endcase
    end

endmodule

// File: tb/tb_serial_alu_engine.sv
// Self-checking bench for serial_alu_engine (WIDTH=8) against an
// arithmetic reference model.
module tb_serial_alu_engine;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         din;
    logic         load_en;
    logic         start;
    logic [2:0]   op;
    logic [1:0]   sel;
    logic [W-1:0] data_out;
    logic         busy;
    logic         done;
    logic         carry;
    logic         zero;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_carry;

    serial_alu_engine #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .din(din), .load_en(load_en),
        .start(start), .op(op), .sel(sel), .data_out(data_out),
        .busy(busy), .done(done), .carry(carry), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Returns {carry, result} from plain integer arithmetic.
    function automatic logic [8:0] ref_alu(input logic [2:0] o,
                                           input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic cf);
        int unsigned ua, ub, s;
        ua = a;
        ub = b;
        case (o)
            3'd0: s = ua + ub;
            3'd1: s = ua + (255 - ub) + 1;
            3'd2: s = ua & ub;
            3'd3: s = ua | ub;
            3'd4: s = ua ^ ub;
            3'd5: s = ua;
            3'd6: s = ub;
            default: s = ua + ub + (cf ? 1 : 0);
        endcase
        return s[8:0];
    endfunction

    task automatic rd(input logic [1:0] s, output logic [7:0] v);
        sel = s;
        #1;
        v = data_out;
    endtask

    task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] v;
        v = {a, b};
        for (int i = 15; i >= 0; i--) begin
            @(negedge clk);
            din = v[i];
            load_en = 1'b1;
        end
        @(negedge clk);
        load_en = 1'b0;
        din = 1'b0;
    endtask

    // Leaves the bench at the negedge where done is expected high.
    task automatic run_op(input logic [2:0] o, output int lat, output int bc);
        @(negedge clk);
        start = 1'b1;
        op = o;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bc = 0;
        while (done !== 1'b1 && lat < 4 * W) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd(2'b11, v);
        n_checks++; if (v !== 8'h02) begin n_fail++; $display("FAIL reset_flags: got %h want 02", v); end
        rd(2'b10, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_result: got %h want 00", v); end
        rd(2'b01, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_sreg: got %h want 00", v); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
        exp_carry = 1'b0;
    endtask

    task automatic test_add();
        logic [7:0] v;
        int lat, bc;
        load_ab(8'h5A, 8'h3C);
        run_op(3'd0, lat, bc);
        n_checks++; if (lat != W) begin n_fail++; $display("FAIL add_latency: got %0d want %0d", lat, W); end
        n_checks++; if (bc != W) begin n_fail++; $display("FAIL add_busy_cycles: got %0d want %0d", bc, W); end
        rd(2'b10, v);
        n_checks++; if (v !== 8'h96) begin n_fail++; $display("FAIL add_result: got %h want 96", v); end
        rd(2'b11, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL add_flags: got %h want 00", v); end
        rd(2'b01, v);
        n_checks++; if (v !== 8'h5A) begin n_fail++; $display("FAIL add_opa: got %h want 5a", v); end
        rd(2'b00, v);
        n_checks++; if (v !== 8'h3C) begin n_fail++; $display("FAIL add_opb: got %h want 3c", v); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got done=%b busy=%b want 0 0", done, busy); end
        exp_carry = 1'b0;
    endtask

    task automatic test_sub();
        logic [7:0] v;
        int lat, bc;
        load_ab(8'h3C, 8'h5A);
        run_op(3'd1, lat, bc);
        rd(2'b10, v);
        n_checks++; if (v !== 8'hE2) begin n_fail++; $display("FAIL sub1_result: got %h want e2", v); end
        n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL sub1_carry: got %b want 0", carry); end
        load_ab(8'h5A, 8'h3C);
        run_op(3'd1, lat, bc);
        rd(2'b10, v);
        n_checks++; if (v !== 8'h1E) begin n_fail++; $display("FAIL sub2_result: got %h want 1e", v); end
        n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL sub2_carry: got %b want 1", carry); end
        exp_carry = 1'b1;
    endtask

    task automatic test_chain();
        logic [7:0] v;
        int lat, bc;
        load_ab(8'hFF, 8'h01);
        run_op(3'd0, lat, bc);
        rd(2'b10, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL chain_add_result: got %h want 00", v); end
        rd(2'b11, v);
        n_checks++; if (v !== 8'h03) begin n_fail++; $display("FAIL chain_add_flags: got %h want 03", v); end
        load_ab(8'h00, 8'h00);
        run_op(3'd7, lat, bc);
        rd(2'b10, v);
        n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL chain_adc_result: got %h want 01", v); end
        rd(2'b11, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL chain_adc_flags: got %h want 00", v); end
        exp_carry = 1'b0;
    endtask

    task automatic test_ignore();
        logic [7:0] v;
        int nd;
        load_ab(8'h11, 8'h22);
        @(negedge clk);
        start = 1'b1;
        op = 3'd0;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int j = 0; j < W + 4; j++) begin
            if (done === 1'b1) nd++;
            if (j == 2) begin start = 1'b1; op = 3'd4; end
            if (j == 3) begin start = 1'b0; load_en = 1'b1; din = 1'b1; end
            if (j == 5) begin load_en = 1'b0; din = 1'b0; end
            @(negedge clk);
        end
        n_checks++; if (nd != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", nd); end
        rd(2'b10, v);
        n_checks++; if (v !== 8'h33) begin n_fail++; $display("FAIL ignore_result: got %h want 33", v); end
        rd(2'b01, v);
        n_checks++; if (v !== 8'h11) begin n_fail++; $display("FAIL ignore_opa: got %h want 11", v); end
        rd(2'b00, v);
        n_checks++; if (v !== 8'h22) begin n_fail++; $display("FAIL ignore_opb: got %h want 22", v); end
        exp_carry = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        int lat, bc;
        load_ab(8'h5A, 8'h3C);
        run_op(3'd3, lat, bc);
        rd(2'b10, v);
        n_checks++; if (v !== 8'h7E) begin n_fail++; $display("FAIL b2b_or_result: got %h want 7e", v); end
        start = 1'b1;
        op = 3'd6;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_restart: got busy=%b done=%b want 1 0", busy, done); end
        lat = 0;
        while (done !== 1'b1 && lat < 4 * W) begin
            @(negedge clk);
            lat++;
        end
        n_checks++; if (lat != W) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", lat, W); end
        rd(2'b10, v);
        n_checks++; if (v !== 8'h3C) begin n_fail++; $display("FAIL b2b_passb_result: got %h want 3c", v); end
        exp_carry = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [7:0] v;
        int lat, bc, nd;
        load_ab(8'h12, 8'h34);
        @(negedge clk);
        start = 1'b1;
        op = 3'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_busy_done: got %b%b want 00", busy, done); end
        rd(2'b10, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL abort_result: got %h want 00", v); end
        rd(2'b11, v);
        n_checks++; if (v !== 8'h02) begin n_fail++; $display("FAIL abort_flags: got %h want 02", v); end
        nd = 0;
        for (int j = 0; j < W + 2; j++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        n_checks++; if (nd != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", nd); end
        exp_carry = 1'b0;
        load_ab(8'hF0, 8'hFF);
        run_op(3'd4, lat, bc);
        rd(2'b10, v);
        n_checks++; if (v !== 8'h0F) begin n_fail++; $display("FAIL abort_xor_result: got %h want 0f", v); end
        rd(2'b11, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL abort_xor_flags: got %h want 00", v); end
    endtask

    task automatic test_random();
        logic [7:0] a, b, v, er;
        logic [2:0] o;
        logic [8:0] r;
        int lat, bc;
        for (int k = 0; k < 24; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            o = 3'($urandom_range(0, 7));
            if (k % 6 == 5) b = 8'(256 - int'(a));
            r = ref_alu(o, a, b, exp_carry);
            er = r[7:0];
            load_ab(a, b);
            run_op(o, lat, bc);
            n_checks++; if (lat != W) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", k, lat, W); end
            rd(2'b10, v);
            n_checks++; if (v !== er) begin n_fail++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h want %h", k, o, a, b, v, er); end
            rd(2'b11, v);
            n_checks++; if (v !== {6'd0, er == 8'h00, r[8]}) begin n_fail++; $display("FAIL rand_flags[%0d] op=%0d: got %h want %h", k, o, v, {6'd0, er == 8'h00, r[8]}); end
            exp_carry = r[8];
        end
    endtask

    initial begin
        rst = 1'b1;
        din = 1'b0;
        load_en = 1'b0;
        start = 1'b0;
        op = 3'd0;
        sel = 2'b00;
        exp_carry = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_chain();
        test_ignore();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_alu_engine.md
Name: serial_alu_engine

Overview:
- Parametrised successor to the 16-bit shift-and-compute tile.
- Two WIDTH-bit operands are loaded bit-serially into one 2*WIDTH shift register.
- On a start pulse, a bit-serial ALU (one bit per clock, LSB first) computes one of eight operations and latches a WIDTH-bit result plus carry/zero flags.
- A select input muxes operand A, operand B, the result or the flags onto a parallel output. The block sits behind the tile's pin interface.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- din  in  1  serial data in
- load_en  in  1  shift din into operand register this cycle
- start  in  1  begin operation (sampled only when idle)
- op  in  3  operation code, latched at start
- sel  in  2  output select
- data_out  out  WIDTH  selected parallel output
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- carry  out  1  carry flag
- zero  out  1  zero flag

Behaviour:
- Reset: synchronous, active-high; clk rising edge is the only clock.
  - Reset values: shift register 0, result 0, carry 0, zero 1, busy 0, done 0, FSM IDLE, bit counter 0.
  - Reset during EXEC aborts the operation with no done pulse; the result is cleared.
- Operand load:
  - When load_en=1 and FSM is IDLE or DONE: sreg <= {sreg[2W-2:0], din}.
  - A = sreg[2W-1:W], B = sreg[W-1:0]; sending A MSB-first then B MSB-first loads both.
  - load_en is ignored while busy.
  - If start=1 and load_en=1 in the same accepted cycle, start wins and no shift occurs.
- FSM states: IDLE, EXEC, DONE.
  - IDLE/DONE + start=1:
    - latch op
    - copy A and B into working registers
    - set carry-in: 1 for SUB, carry flag for ADC, 0 otherwise
    - clear counter
    - go to EXEC
  - EXEC, one bit per cycle:
    - bit i of A and B (working registers shifted right) feeds a 1-bit adder/logic slice.
    - The result bit enters result MSB and the result shifts right.
    - After WIDTH EXEC cycles (counter == WIDTH-1), go to DONE.
  - DONE lasts exactly one cycle (done=1), then IDLE unless start is accepted in that same cycle.
- busy=1 exactly while in EXEC: WIDTH cycles.
- Latency: start sampled at edge 0; result, carry and zero are valid at the edge where done rises, which is edge WIDTH.
- start while busy is ignored, not queued.
- sreg is not modified by EXEC, so the operands can be reused.
- Opcodes; carry is the carry out of the MSB unless stated:
  - 000 ADD: A+B
  - 001 SUB: A+~B+1; carry=1 means no borrow
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 PASS_A
  - 110 PASS_B
  - 111 ADC: A+B+carry_flag
  - Logic and pass ops clear carry.
- zero: updated at completion to (result == 0).
- Flags and result hold until the next completed operation.
- Arithmetic is modulo 2^WIDTH.
- Output mux, combinational from registers:
  - sel 00 → B
  - sel 01 → A
  - sel 10 → result
  - sel 11 → {zeros, zero, carry}, i.e. carry at bit 0 and zero at bit 1
- During EXEC, result reads as the partially shifted value; it is not guaranteed until done.
- Bit counter width: clog2(WIDTH).

Test Plan (WIDTH=8):
- Reset, sel=11 → data_out=0x02; sel=10 → 0x00; busy=0.
- Load A=0x5A, B=0x3C (16 serial bits), op=ADD, start → busy high 8 cycles, done at edge 8, result 0x96, carry=0, zero=0; sel=01 → 0x5A, sel=00 → 0x3C.
- A=0x3C, B=0x5A, SUB → result 0xE2, carry=0. Then A=0x5A, B=0x3C, SUB → 0x1E, carry=1.
- Chain: A=0xFF, B=0x01, ADD → 0x00, carry=1, zero=1. Then load A=0x00, B=0x00, ADC → 0x01, carry=0, zero=0.
- Start mid-EXEC and load_en pulses mid-EXEC → both ignored: sreg unchanged, a single done pulse, result from the original op. start asserted in the DONE cycle → a new EXEC begins immediately.
- Reset asserted at EXEC cycle 4 → no done pulse, busy=0 next cycle, result=0, zero=1. A subsequent XOR with A=0xF0, B=0xFF → 0x0F.
